// File: rtl/arbitro_mux_rr.sv
// ============================================================================
// Module      : arbitro_mux_rr
// Description : Two-source round-robin arbiter driving a 2:1 mux selector and a
//               one-entry registered output with saturating per-source counters.
//               Optional macro ARB_BURST_EN keeps a grant for up to BURST_LEN beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_mux_rr #(
    parameter int DATA_W    = 2,
    parameter int CNT_W     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in0,
    output logic              ready_in0,
    input  logic              valid_in1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              ready_in1,
    output logic              selector,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_out,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                last_q,      last_d;
    logic                sel_hold_q,  sel_hold_d;
    logic                valid_out_q, valid_out_d;
    logic [DATA_W-1:0]   data_out_q,  data_out_d;
    logic [CNT_W-1:0]    cnt0_q,      cnt0_d;
    logic [CNT_W-1:0]    cnt1_q,      cnt1_d;

    logic                w_slot_free;
    logic                w_xfer0;
    logic                w_xfer1;

`ifdef ARB_BURST_EN
    localparam int                BCNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(BURST_LEN);

    logic [BCNT_W-1:0]   burst_q, burst_d;
    logic [BCNT_W-1:0]   w_beats;
`endif

    // Tie goes to the source that did not win last time.
    function automatic state_t arbitrate(input logic v0, input logic v1, input logic lst);
        if (v0 && v1)
            return lst ? GRANT0 : GRANT1;
        else if (v0)
            return GRANT0;
        else if (v1)
            return GRANT1;
        else
            return IDLE;
    endfunction

    always_comb begin
        w_slot_free = !valid_out_q || ready_out;
        ready_in0   = (state_q == GRANT0) && w_slot_free;
        ready_in1   = (state_q == GRANT1) && w_slot_free;
        w_xfer0     = valid_in0 && ready_in0;
        w_xfer1     = valid_in1 && ready_in1;
        if (state_q == GRANT1)
            selector = 1'b1;
        else if (state_q == GRANT0)
            selector = 1'b0;
        else
            selector = sel_hold_q;
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

    // Output register and counters: a new beat may enter in the same cycle
    // the previous one drains, so valid_out only drops on a drain without refill.
    always_comb begin
        last_d      = last_q;
        sel_hold_d  = selector;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        if (w_xfer0) begin
            data_out_d  = data_in0;
            valid_out_d = 1'b1;
            last_d      = 1'b0;
            cnt0_d      = (cnt0_q == {CNT_W{1'b1}}) ? cnt0_q : cnt0_q + CNT_W'(1);
        end else if (w_xfer1) begin
            data_out_d  = data_in1;
            valid_out_d = 1'b1;
            last_d      = 1'b1;
            cnt1_d      = (cnt1_q == {CNT_W{1'b1}}) ? cnt1_q : cnt1_q + CNT_W'(1);
        end else if (valid_out_q && ready_out) begin
            valid_out_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef ARB_BURST_EN
        burst_d = burst_q;
        w_beats = burst_q + BCNT_W'(1);
`endif
        case (state_q)
            IDLE: state_d = arbitrate(valid_in0, valid_in1, last_q);
            GRANT0: begin
                if (w_xfer0) begin
`ifdef ARB_BURST_EN
                    if (w_beats < BURST_MAX)
                        state_d = GRANT0;
                    else if (valid_in1)
                        state_d = GRANT1;
                    else
                        state_d = GRANT0;
`else
                    if (valid_in1)
                        state_d = GRANT1;
                    else if (valid_in0)
                        state_d = GRANT0;
                    else
                        state_d = IDLE;
`endif
                end else if (!valid_in0) begin
                    state_d = arbitrate(valid_in0, valid_in1, last_q);
                end else begin
                    state_d = GRANT0;
                end
            end
            GRANT1: begin
                if (w_xfer1) begin
`ifdef ARB_BURST_EN
                    if (w_beats < BURST_MAX)
                        state_d = GRANT1;
                    else if (valid_in0)
                        state_d = GRANT0;
                    else
                        state_d = GRANT1;
`else
                    if (valid_in0)
                        state_d = GRANT0;
                    else if (valid_in1)
                        state_d = GRANT1;
                    else
                        state_d = IDLE;
`endif
                end else if (!valid_in1) begin
                    state_d = arbitrate(valid_in0, valid_in1, last_q);
                end else begin
                    state_d = GRANT1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef ARB_BURST_EN
        // A full burst or a grant change starts a fresh burst count.
        if ((w_xfer0 || w_xfer1) && (state_d == state_q) && (w_beats < BURST_MAX))
            burst_d = w_beats;
        else if ((state_d != state_q) || w_xfer0 || w_xfer1)
            burst_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            sel_hold_q  <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
`ifdef ARB_BURST_EN
            burst_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_hold_q  <= sel_hold_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
`ifdef ARB_BURST_EN
            burst_q     <= burst_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arbitro_mux_rr.sv
// ============================================================================
// Module      : tb_arbitro_mux_rr
// Description : Scoreboard bench for arbitro_mux_rr: handshaking source models,
//               expected output order queued at stimulus time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_mux_rr;

    localparam int DATA_W    = 2;
    localparam int CNT_W     = 8;
    localparam int BURST_LEN = 4;
`ifdef ARB_BURST_EN
    localparam int RUN_LEN = BURST_LEN;
`else
    localparam int RUN_LEN = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in0, valid_in1;
    logic [DATA_W-1:0] data_in0, data_in1;
    logic              ready_in0, ready_in1;
    logic              selector;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              ready_out;
    logic [CNT_W-1:0]  cnt0, cnt1;

    logic              s_ready_in0, s_ready_in1, s_selector, s_valid_out;
    logic [DATA_W-1:0] s_data_out;
    logic [1:0]        s_cnt0, s_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              hs0 = 1'b0;
    logic              hs1 = 1'b0;

    always #5 clk = ~clk;

    arbitro_mux_rr #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN)) u_dut (
        .clk(clk), .reset(reset),
        .valid_in0(valid_in0), .data_in0(data_in0), .ready_in0(ready_in0),
        .valid_in1(valid_in1), .data_in1(data_in1), .ready_in1(ready_in1),
        .selector(selector), .valid_out(valid_out), .data_out(data_out),
        .ready_out(ready_out), .cnt0(cnt0), .cnt1(cnt1)
    );

    // Narrow-counter copy to observe saturation.
    arbitro_mux_rr #(.DATA_W(DATA_W), .CNT_W(2), .BURST_LEN(BURST_LEN)) u_dut_sat (
        .clk(clk), .reset(reset),
        .valid_in0(valid_in0), .data_in0(data_in0), .ready_in0(s_ready_in0),
        .valid_in1(valid_in1), .data_in1(data_in1), .ready_in1(s_ready_in1),
        .selector(s_selector), .valid_out(s_valid_out), .data_out(s_data_out),
        .ready_out(ready_out), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshake sampling and scoreboard pop, away from the active edge.
    always @(negedge clk) begin
        hs0 = valid_in0 && ready_in0;
        hs1 = valid_in1 && ready_in1;
        if (hs0) check_value("sel_on_src0", {31'd0, selector}, 32'd0);
        if (hs1) check_value("sel_on_src1", {31'd0, selector}, 32'd1);
        if (!reset && valid_out && ready_out) begin
            if (exp_q.size() == 0)
                check_value("unexpected_out", exp_q.size(), 32'd1);
            else
                check_value("data_out", {30'd0, data_out}, {30'd0, exp_q.pop_front()});
        end
    end

    task automatic refresh();
        valid_in0 = (q0.size() > 0);
        data_in0  = valid_in0 ? q0[0] : '0;
        valid_in1 = (q1.size() > 0);
        data_in1  = valid_in1 ? q1[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        refresh();
    endtask

    task automatic do_reset();
        ready_out = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        refresh();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int c = 0;
        while ((q0.size() + q1.size() + exp_q.size()) > 0 && c < max_cycles) begin
            tick();
            c++;
        end
        check_value("drain_timeout", q0.size() + q1.size() + exp_q.size(), 32'd0);
        tick();
        tick();
    endtask

    // Both sources loaded with n beats; arbitration order alternates in runs of RUN_LEN.
    task automatic push_both(input int n, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        for (int i = 0; i < 2 * n; i++) begin
            if (((i / RUN_LEN) % 2) == 0) begin
                q0.push_back(d0);
                exp_q.push_back(d0);
            end else begin
                q1.push_back(d1);
                exp_q.push_back(d1);
            end
        end
        refresh();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] v;
        reset     = 1'b1;
        ready_out = 1'b1;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check_value("rst_data_out",  {30'd0, data_out},  32'd0);
        check_value("rst_selector",  {31'd0, selector},  32'd0);
        check_value("rst_ready",     {30'd0, ready_in1, ready_in0}, 32'd0);
        check_value("rst_cnt",       {16'd0, cnt1, cnt0}, 32'd0);
        reset = 1'b0;

        // Single source latency
        q0.push_back(2'b10);
        exp_q.push_back(2'b10);
        refresh();
        @(negedge clk);
        check_value("lat_ready_t0", {31'd0, ready_in0}, 32'd0);
        tick();
        @(negedge clk);
        check_value("lat_ready_t1", {31'd0, ready_in0}, 32'd1);
        check_value("lat_sel_t1",   {31'd0, selector},  32'd0);
        check_value("lat_valid_t1", {31'd0, valid_out}, 32'd0);
        tick();
        @(negedge clk);
        check_value("lat_valid_t2", {31'd0, valid_out}, 32'd1);
        check_value("lat_data_t2",  {30'd0, data_out},  32'd2);
        check_value("lat_cnt0_t2",  {24'd0, cnt0},      32'd1);
        drain(20);

        // Both sources continuously valid
        do_reset();
        push_both(4, 2'b01, 2'b11);
        drain(40);
        check_value("both_cnt0", {24'd0, cnt0}, 32'd4);
        check_value("both_cnt1", {24'd0, cnt1}, 32'd4);

        // Backpressure: ready_out low for three cycles mid-stream
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = DATA_W'(i);
            q0.push_back(v);
            exp_q.push_back(v);
        end
        refresh();
        repeat (4) tick();
        ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_value("bp_ready_in0", {31'd0, ready_in0}, 32'd0);
            check_value("bp_data_hold", {30'd0, data_out},  32'd2);
            check_value("bp_cnt_hold",  {24'd0, cnt0},      32'd3);
            check_value("bp_valid",     {31'd0, valid_out}, 32'd1);
            tick();
        end
        ready_out = 1'b1;
        drain(40);
        check_value("bp_cnt0_final", {24'd0, cnt0}, 32'd8);

        // Counter saturation on the narrow copy
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v = DATA_W'(3 - (i % 4));
            q1.push_back(v);
            exp_q.push_back(v);
        end
        refresh();
        drain(40);
        check_value("sat_cnt1",  {30'd0, s_cnt1}, 32'd3);
        check_value("sat_cnt0",  {30'd0, s_cnt0}, 32'd0);
        check_value("wide_cnt1", {24'd0, cnt1},   32'd5);

        // Longer contention run (bursts when enabled, alternation otherwise)
        do_reset();
        push_both(8, 2'b00, 2'b10);
        drain(60);
        check_value("run_cnt0", {24'd0, cnt0}, 32'd8);
        check_value("run_cnt1", {24'd0, cnt1}, 32'd8);

        // Asynchronous reset while a beat sits in the output register
        do_reset();
        ready_out = 1'b0;
        q0.push_back(2'b11);
        q0.push_back(2'b01);
        refresh();
        repeat (3) tick();
        @(negedge clk);
        check_value("pre_rst_valid", {31'd0, valid_out}, 32'd1);
        check_value("pre_rst_data",  {30'd0, data_out},  32'd3);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_value("arst_valid_out", {31'd0, valid_out}, 32'd0);
        check_value("arst_data_out",  {30'd0, data_out},  32'd0);
        check_value("arst_cnt0",      {24'd0, cnt0},      32'd0);
        check_value("arst_ready",     {30'd0, ready_in1, ready_in0}, 32'd0);
        check_value("arst_selector",  {31'd0, selector},  32'd0);
        q0.delete();
        q1.delete();
        exp_q.delete();
        refresh();
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_out = 1'b1;
        @(negedge clk);
        check_value("post_rst_idle", {30'd0, ready_in1, ready_in0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
